// File: rtl/cpu_pkg.sv
// Shared CPU definitions: flag indices, flag-write classes, condition codes,
// and the branch-shadow controller states.
package cpu_pkg;

  // Bit positions inside the packed {N,Z,C,V} flag word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Flag-write class of an instruction
  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_CV   = 2'b01;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_ALL  = 2'b11;

  // ARM-style condition field
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Branch-shadow controller
  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } shadow_state_e;

endpackage

// File: rtl/exec_cond_stage_squash_ctr.sv
// Branch-shadow squash controller: after a taken branch, marks the next
// SHADOW_DEPTH unstalled E slots as wrong-path. Slots are counted whether
// or not they hold an instruction.
module squash_ctr
  import cpu_pkg::*;
#(
  parameter int SHADOW_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_stall,
  output logic o_squashing
);

  localparam int CW = $clog2(SHADOW_DEPTH + 1);

  shadow_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;

  // State and slot counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next state: a stall freezes everything, otherwise count down the shadow
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      RUN: begin
        if (!i_stall && i_start) begin
          w_state_nxt = SHADOW;
          w_count_nxt = CW'(SHADOW_DEPTH);
        end
      end
      SHADOW: begin
        if (!i_stall) begin
          w_count_nxt = r_count - CW'(1);
          if (r_count == CW'(1)) w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_count_nxt = '0;
      end
    endcase
  end

  // Output: the current E slot is in the shadow
  always_comb begin
    o_squashing = (r_state == SHADOW);
  end

endmodule

// File: rtl/exec_cond_stage.sv
// Execute-stage conditional execution: owns the NZCV register, gates the
// E-stage side effects on the condition result, resolves taken branches and
// squashes the wrong-path slots behind them before registering into M.
module exec_cond_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int SHADOW_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidE,
  input  logic              CondEx,
  input  logic [3:0]        FlagsIn,
  input  logic [1:0]        FlagW,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemtoRegE,
  input  logic              PCSrcE,
  input  logic              BranchE,
  input  logic [3:0]        WA3E,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  output logic [3:0]        FlagsE,
  output logic              PCSrcTakenE,
  output logic              Squashing,
  output logic              ValidM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemtoRegM,
  output logic [3:0]        WA3M,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM
);

  logic w_live;
  logic w_exec;

  // live is formed first so an unknown CondEx on a dead slot stays masked
  assign w_live      = ValidE & ~FlushE & ~Squashing;
  assign w_exec      = w_live & CondEx;
  assign PCSrcTakenE = w_exec & (PCSrcE | BranchE);

  squash_ctr #(.SHADOW_DEPTH(SHADOW_DEPTH)) u_squash (
    .clk         (clk),
    .reset       (reset),
    .i_start     (PCSrcTakenE),
    .i_stall     (StallE),
    .o_squashing (Squashing)
  );

  // Flag register: only executed, flag-setting, unstalled instructions update it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      FlagsE <= 4'b0000;
    else if (!StallE && w_exec && (FlagW != FW_NONE))
      FlagsE <= FlagsIn;
  end

  // E->M register: a stall sends a bubble into M but keeps the data fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      WA3M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
    end else if (StallE) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
    end else begin
      ValidM     <= w_live;
      RegWriteM  <= w_exec & RegWriteE;
      MemWriteM  <= w_exec & MemWriteE;
      MemtoRegM  <= w_exec & MemtoRegE;
      WA3M       <= WA3E;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
    end
  end

endmodule

// File: tb/tb_exec_cond_stage.sv
// Bench for exec_cond_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the stage.
module tb_exec_cond_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          StallE, FlushE, ValidE, CondEx;
  logic [3:0]    FlagsIn;
  logic [1:0]    FlagW;
  logic          RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchE;
  logic [3:0]    WA3E;
  logic [DW-1:0] ALUResultE, WriteDataE;
  logic [3:0]    FlagsE;
  logic          PCSrcTakenE, Squashing;
  logic          ValidM, RegWriteM, MemWriteM, MemtoRegM;
  logic [3:0]    WA3M;
  logic [DW-1:0] ALUResultM, WriteDataM;

  exec_cond_stage #(.DATA_W(DW), .SHADOW_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidE(ValidE),
    .CondEx(CondEx), .FlagsIn(FlagsIn), .FlagW(FlagW), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE), .BranchE(BranchE),
    .WA3E(WA3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .FlagsE(FlagsE), .PCSrcTakenE(PCSrcTakenE), .Squashing(Squashing),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .WA3M(WA3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state
  logic [3:0]    m_flags;
  int            m_shadow;   // remaining squashed slots
  logic          m_valid, m_rw, m_mw, m_mr;
  logic [3:0]    m_wa;
  logic [DW-1:0] m_alu, m_wd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = 4'b0; m_shadow = 0;
    m_valid = 0; m_rw = 0; m_mw = 0; m_mr = 0;
    m_wa = '0; m_alu = '0; m_wd = '0;
  endtask

  task automatic clr();
    StallE = 0; FlushE = 0; ValidE = 0; CondEx = 0; FlagsIn = 4'b0; FlagW = 2'b00;
    RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0; BranchE = 0;
    WA3E = 4'h0; ALUResultE = '0; WriteDataE = '0;
  endtask

  task automatic instr(input logic c, input logic [1:0] fw, input logic [3:0] fin,
                       input logic rw, input logic mw, input logic br);
    clr();
    ValidE = 1; CondEx = c; FlagW = fw; FlagsIn = fin;
    RegWriteE = rw; MemWriteE = mw; BranchE = br;
    WA3E = 4'($urandom); ALUResultE = $urandom; WriteDataE = $urandom;
  endtask

  // Called just after a negedge with inputs applied: check combinational
  // outputs, advance one clock, then check registered outputs.
  task automatic step();
    bit sq, live, ex, tk;
    sq   = (m_shadow > 0);
    live = ValidE && !FlushE && !sq;
    ex   = live && (CondEx === 1'b1);
    tk   = ex && (PCSrcE || BranchE);
    #1;
    chk("Squashing", DW'(Squashing), DW'(sq));
    chk("PCSrcTakenE", DW'(PCSrcTakenE), DW'(tk));
    chk("FlagsE_pre", DW'(FlagsE), DW'(m_flags));
    if (!StallE) begin
      m_valid = live; m_rw = ex && RegWriteE; m_mw = ex && MemWriteE; m_mr = ex && MemtoRegE;
      m_wa = WA3E; m_alu = ALUResultE; m_wd = WriteDataE;
      if (ex && FlagW != 2'b00) m_flags = FlagsIn;
      if (m_shadow > 0) m_shadow--;
      else if (tk) m_shadow = DEPTH;
    end else begin
      m_valid = 0; m_rw = 0; m_mw = 0; m_mr = 0;
    end
    @(posedge clk); #1;
    chk("FlagsE", DW'(FlagsE), DW'(m_flags));
    chk("ValidM", DW'(ValidM), DW'(m_valid));
    chk("RegWriteM", DW'(RegWriteM), DW'(m_rw));
    chk("MemWriteM", DW'(MemWriteM), DW'(m_mw));
    chk("MemtoRegM", DW'(MemtoRegM), DW'(m_mr));
    chk("WA3M", DW'(WA3M), DW'(m_wa));
    chk("ALUResultM", ALUResultM, m_alu);
    chk("WriteDataM", WriteDataM, m_wd);
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset = 1;
    model_reset();
    @(negedge clk); #1;
    chk("rst_FlagsE", DW'(FlagsE), 0);
    chk("rst_ValidM", DW'(ValidM), 0);
    chk("rst_Squashing", DW'(Squashing), 0);
    @(negedge clk);
    reset = 0;

    // Test 2: executed flag-setting op, no register write
    instr(1, 2'b11, 4'b0100, 0, 0, 0); step();
    chk("t2_FlagsE", DW'(FlagsE), 32'h4);
    chk("t2_ValidM", DW'(ValidM), 1);
    chk("t2_RegWriteM", DW'(RegWriteM), 0);

    // Test 3: failed condition suppresses every side effect
    instr(0, 2'b11, 4'b1000, 1, 1, 0); step();
    chk("t3_FlagsE", DW'(FlagsE), 32'h4);
    chk("t3_RegWriteM", DW'(RegWriteM), 0);
    chk("t3_MemWriteM", DW'(MemWriteM), 0);
    chk("t3_ValidM", DW'(ValidM), 1);

    // Test 4: taken branch squashes the next two slots
    instr(1, 2'b00, 4'b0, 0, 0, 1); #1;
    chk("t4_taken", DW'(PCSrcTakenE), 1);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      instr(1, 2'b11, 4'b1111, 1, 0, 0); step();
      chk("t4_shadow_RegWriteM", DW'(RegWriteM), 0);
      chk("t4_shadow_ValidM", DW'(ValidM), 0);
      chk("t4_shadow_FlagsE", DW'(FlagsE), 32'h4);
    end
    instr(1, 2'b00, 4'b0, 1, 0, 0); step();
    chk("t4_after_RegWriteM", DW'(RegWriteM), 1);

    // Test 5: stalls inside the shadow freeze the slot count
    instr(1, 2'b00, 4'b0, 0, 0, 1); step();
    for (int i = 0; i < 3; i++) begin
      instr(1, 2'b00, 4'b0, 1, 0, 0); StallE = 1; step();
      chk("t5_bubble", DW'(ValidM), 0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      instr(1, 2'b00, 4'b0, 1, 0, 0); #1;
      chk("t5_sq", DW'(Squashing), 1);
      step();
    end
    instr(1, 2'b00, 4'b0, 1, 0, 0); #1;
    chk("t5_sq_end", DW'(Squashing), 0);
    step();

    // Test 6: flush kills a store; stall+flush keeps flags and shadow count
    instr(1, 2'b11, 4'b0011, 0, 1, 0); FlushE = 1; step();
    chk("t6_MemWriteM", DW'(MemWriteM), 0);
    chk("t6_ValidM", DW'(ValidM), 0);
    instr(1, 2'b00, 4'b0, 0, 0, 1); step();
    instr(1, 2'b11, 4'b0011, 0, 0, 0); StallE = 1; FlushE = 1; step();
    chk("t6_sf_FlagsE", DW'(FlagsE), 32'h4);
    instr(1, 2'b11, 4'b0011, 0, 0, 0); step();
    instr(1, 2'b11, 4'b0011, 0, 0, 0); step();  // last shadow slot
    chk("t6_count_held_FlagsE", DW'(FlagsE), 32'h4);

    // Test 1: reset asserted mid-shadow with FlagsE=1010
    instr(1, 2'b11, 4'b1010, 0, 0, 0); step();
    instr(1, 2'b00, 4'b0, 1, 0, 1); step();
    instr(1, 2'b00, 4'b0, 1, 0, 0); #2;
    reset = 1; #1;
    chk("t1_FlagsE", DW'(FlagsE), 0);
    chk("t1_ValidM", DW'(ValidM), 0);
    chk("t1_Squashing", DW'(Squashing), 0);
    model_reset();
    @(negedge clk);
    reset = 0;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      clr();
      ValidE     = ($urandom_range(0, 9) < 8);
      StallE     = ($urandom_range(0, 9) < 2);
      FlushE     = ($urandom_range(0, 9) < 1);
      CondEx     = ValidE ? 1'($urandom) : 1'bx;
      FlagW      = 2'($urandom);
      FlagsIn    = 4'($urandom);
      RegWriteE  = 1'($urandom);
      MemWriteE  = 1'($urandom);
      MemtoRegE  = 1'($urandom);
      BranchE    = ($urandom_range(0, 9) < 2);
      PCSrcE     = ($urandom_range(0, 19) < 1);
      WA3E       = 4'($urandom);
      ALUResultE = $urandom;
      WriteDataE = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Bound on total runtime in case the sequence stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
